// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for the 4-way, 16-set, 256-bit-line L2 cache.
// Sequences tag check, dirty writeback, line fill and install for one L1
// request at a time, and drives the physical-memory handshake.
// Optional build macro L2_PERF_CNT_EN enables the hit/miss performance counters;
// when undefined, hit_count/miss_count are tied to zero.
module l2_cache_control #(
  parameter int unsigned PMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l2cmem_read,
  input  logic        l2cmem_write,
  input  logic        hit,
  input  logic [3:0]  which_way_hit,
  input  logic        dirty_bit_out,
  input  logic [2:0]  lru_way,
  input  logic        pmem_resp,
  output logic        l2cmem_resp,
  output logic        cache_write,
  output logic        valid_bit_in,
  output logic        dirty_bit_in,
  output logic [1:0]  way_select,
  output logic        pmem_address_sel,
  output logic        dirty_write_sel,
  output logic        unleash_l2cmem_address,
  output logic        unleash_l2cmem_wdata,
  output logic        unleash_l2cmem_rdata,
  output logic        unleash_pmem_rdata,
  output logic        unleash_pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        err_timeout,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned TO_W  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_WB,
    S_FILL,
    S_INSTALL
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        victim_q, victim_d;
  logic              op_write_q, op_write_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        hit_way;
  logic [1:0]        lru_victim;

  // Lowest-numbered hitting way (way0 sits in bit 3 of the hit vector)
  always_comb begin
    hit_way = 2'd0;
    if (which_way_hit[3])      hit_way = 2'd0;
    else if (which_way_hit[2]) hit_way = 2'd1;
    else if (which_way_hit[1]) hit_way = 2'd2;
    else if (which_way_hit[0]) hit_way = 2'd3;
  end

  // Pseudo-LRU tree walk: bit0 picks the half, bit2/bit1 the way within it
  assign lru_victim = lru_way[0] ? (lru_way[2] ? 2'd3 : 2'd2)
                                 : (lru_way[1] ? 2'd1 : 2'd0);

  // State, victim, op and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      victim_q   <= 2'd0;
      op_write_q <= 1'b0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      op_write_q <= op_write_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d                = state_q;
    victim_d               = victim_q;
    op_write_d             = op_write_q;
    to_cnt_d               = to_cnt_q;
    err_d                  = err_q;
    l2cmem_resp            = 1'b0;
    cache_write            = 1'b0;
    valid_bit_in           = 1'b0;
    dirty_bit_in           = 1'b0;
    way_select             = 2'd0;
    pmem_address_sel       = 1'b0;
    dirty_write_sel        = 1'b0;
    unleash_l2cmem_address = 1'b0;
    unleash_l2cmem_wdata   = 1'b0;
    unleash_l2cmem_rdata   = 1'b0;
    unleash_pmem_rdata     = 1'b0;
    unleash_pmem_address   = 1'b0;
    pmem_read              = 1'b0;
    pmem_write             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (l2cmem_read || l2cmem_write) begin
          unleash_l2cmem_address = 1'b1;
          unleash_l2cmem_wdata   = l2cmem_write;
          op_write_d             = l2cmem_write;
          state_d                = S_TAG;
        end
      end
      S_TAG: begin
        if (hit) begin
          way_select  = hit_way;
          l2cmem_resp = 1'b1;
          if (op_write_q) begin
            cache_write     = 1'b1;
            dirty_write_sel = 1'b1;
            valid_bit_in    = 1'b1;
            dirty_bit_in    = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          way_select           = lru_victim;
          victim_d             = lru_victim;
          unleash_pmem_address = 1'b1;
          to_cnt_d             = '0;
          if (dirty_bit_out) begin
            pmem_address_sel     = 1'b1;
            unleash_l2cmem_rdata = 1'b1;
            state_d              = S_WB;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_WB: begin
        way_select = victim_q;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          unleash_pmem_address = 1'b1;
          to_cnt_d             = '0;
          state_d              = S_FILL;
        end
      end
      S_FILL: begin
        way_select         = victim_q;
        pmem_read          = 1'b1;
        unleash_pmem_rdata = pmem_resp;
        if (pmem_resp) state_d = S_INSTALL;
      end
      S_INSTALL: begin
        way_select   = victim_q;
        cache_write  = 1'b1;
        valid_bit_in = 1'b1;
        state_d      = S_TAG;
      end
      default: state_d = S_IDLE;
    endcase

    // Waiting on memory: count, flag (sticky) when the limit is reached, keep waiting
    if ((state_q == S_WB || state_q == S_FILL) && !pmem_resp) begin
      if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
      if (PMEM_TIMEOUT != 0 && (to_cnt_q + TO_W'(1)) == TO_W'(PMEM_TIMEOUT)) err_d = 1'b1;
    end
  end

  assign err_timeout = err_q;

`ifdef L2_PERF_CNT_EN
  logic             recheck_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  // Marks the TAG visit that follows INSTALL so it is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      recheck_q <= 1'b0;
    else if (state_q == S_INSTALL)   recheck_q <= 1'b1;
    else if (state_q == S_IDLE)      recheck_q <= 1'b0;
  end

  // First-look hit/miss counters, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_TAG && !recheck_q) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      else     miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: transaction-level scenarios expanded into
// per-cycle expected output vectors, checked by one compare process.
module tb_l2_cache_control;

  localparam int TO = 8;
`ifdef L2_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        l2cmem_read, l2cmem_write, hit, dirty_bit_out, pmem_resp;
  logic [3:0]  which_way_hit;
  logic [2:0]  lru_way;
  logic        l2cmem_resp, cache_write, valid_bit_in, dirty_bit_in;
  logic [1:0]  way_select;
  logic        pmem_address_sel, dirty_write_sel, unleash_l2cmem_address, unleash_l2cmem_wdata;
  logic        unleash_l2cmem_rdata, unleash_pmem_rdata, unleash_pmem_address;
  logic        pmem_read, pmem_write, err_timeout;
  logic [31:0] hit_count, miss_count;

  l2_cache_control #(.PMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .l2cmem_read(l2cmem_read), .l2cmem_write(l2cmem_write),
    .hit(hit), .which_way_hit(which_way_hit), .dirty_bit_out(dirty_bit_out),
    .lru_way(lru_way), .pmem_resp(pmem_resp),
    .l2cmem_resp(l2cmem_resp), .cache_write(cache_write),
    .valid_bit_in(valid_bit_in), .dirty_bit_in(dirty_bit_in),
    .way_select(way_select), .pmem_address_sel(pmem_address_sel),
    .dirty_write_sel(dirty_write_sel),
    .unleash_l2cmem_address(unleash_l2cmem_address),
    .unleash_l2cmem_wdata(unleash_l2cmem_wdata),
    .unleash_l2cmem_rdata(unleash_l2cmem_rdata),
    .unleash_pmem_rdata(unleash_pmem_rdata),
    .unleash_pmem_address(unleash_pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .err_timeout(err_timeout), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       resp, cw, vin, din;
    logic [1:0] way;
    logic       asel, dws, ua, uw, ur, upr, upa, prd, pwr, err;
  } ov_t;

  typedef struct packed {
    ov_t         o;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  ov_t  act_o;
  assign act_o = {l2cmem_resp, cache_write, valid_bit_in, dirty_bit_in, way_select,
                  pmem_address_sel, dirty_write_sel, unleash_l2cmem_address,
                  unleash_l2cmem_wdata, unleash_l2cmem_rdata, unleash_pmem_rdata,
                  unleash_pmem_address, pmem_read, pmem_write, err_timeout};

  exp_t        expq[$];
  exp_t        ce;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          resp_cyc = -1;
  logic        m_err = 1'b0;
  logic [31:0] m_hc = '0;
  logic [31:0] m_mc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: one expected vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      n_cmp++;
      if ({act_o, hit_count, miss_count} !== ce) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got o=%h hc=%0d mc=%0d want o=%h hc=%0d mc=%0d",
                 cyc, act_o, hit_count, miss_count, ce.o, ce.hc, ce.mc);
      end
    end
    if (l2cmem_resp) resp_cyc = cyc;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Tree pLRU: bit0 selects the upper (ways 2,3) or lower (ways 0,1) half
  function automatic logic [1:0] victim_of(input logic [2:0] l);
    int half, pick;
    half = l[0] ? 2 : 0;
    pick = l[0] ? int'(l[2]) : int'(l[1]);
    return 2'(half + pick);
  endfunction

  task automatic push(input ov_t o);
    exp_t e;
    o.err = m_err;
    e.o   = o;
    e.hc  = m_hc;
    e.mc  = m_mc;
    expq.push_back(e);
  endtask

  // Advance one cycle; inputs the FSM must ignore in this cycle get junk
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    hit           = 1'($urandom);
    which_way_hit = 4'($urandom);
    dirty_bit_out = 1'($urandom);
    lru_way       = 3'($urandom);
    pmem_resp     = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      l2cmem_read  = 1'b0;
      l2cmem_write = 1'b0;
      push('0);
    end
  endtask

  task automatic tag_hit(input bit wr, input logic [1:0] w, input bit first);
    logic [3:0] oh;
    ov_t        o;
    oh            = 4'b1000 >> w;
    hit           = 1'b1;
    which_way_hit = oh | (4'($urandom) & (oh - 4'd1));
    o             = '0;
    o.way         = w;
    o.resp        = 1'b1;
    if (wr) begin
      o.cw  = 1'b1;
      o.dws = 1'b1;
      o.vin = 1'b1;
      o.din = 1'b1;
    end
    push(o);
    if (PERF && first) m_hc++;
  endtask

  // Memory wait of lat idle cycles then a resp cycle
  task automatic wait_phase(input bit wb, input int lat, input logic [1:0] v);
    ov_t o;
    for (int k = 0; k <= lat; k++) begin
      begin_cycle();
      pmem_resp = (k == lat);
      o         = '0;
      o.way     = v;
      o.pwr     = wb;
      o.prd     = !wb;
      if (k == lat) begin
        if (wb) o.upa = 1'b1;
        else    o.upr = 1'b1;
      end
      if (k >= TO) m_err = 1'b1;
      push(o);
    end
  endtask

  task automatic run_txn(input bit wr, input bit miss, input logic [1:0] way,
                         input logic [2:0] lru, input bit dirty, input int wl,
                         input int fl, output int c0);
    ov_t        o;
    logic [1:0] v;
    begin_cycle();
    c0           = cyc;
    l2cmem_write = wr;
    l2cmem_read  = wr ? 1'($urandom) : 1'b1;
    o            = '0;
    o.ua         = 1'b1;
    o.uw         = wr;
    push(o);
    begin_cycle();
    if (!miss) begin
      tag_hit(wr, way, 1'b1);
    end else begin
      v             = victim_of(lru);
      hit           = 1'b0;
      which_way_hit = 4'd0;
      lru_way       = lru;
      dirty_bit_out = dirty;
      o             = '0;
      o.way         = v;
      o.upa         = 1'b1;
      o.asel        = dirty;
      o.ur          = dirty;
      push(o);
      if (PERF) m_mc++;
      if (dirty) wait_phase(1'b1, wl, v);
      wait_phase(1'b0, fl, v);
      begin_cycle();
      o     = '0;
      o.way = v;
      o.cw  = 1'b1;
      o.vin = 1'b1;
      push(o);
      begin_cycle();
      tag_hit(wr, v, 1'b0);
    end
  endtask

  task automatic check_lat(input string nm, input int c0, input int want);
    @(negedge clk);
    #1;
    chk(nm, 64'(resp_cyc - c0), 64'(want));
  endtask

  initial begin
    int  c0;
    ov_t o;
    rst_n = 1'b0;
    l2cmem_read = 1'b0; l2cmem_write = 1'b0; hit = 1'b0; which_way_hit = 4'd0;
    dirty_bit_out = 1'b0; lru_way = 3'd0; pmem_resp = 1'b0;
    #12;
    chk("reset_outputs", 64'(act_o), 64'd0);
    chk("reset_hit_count", 64'(hit_count), 64'd0);
    chk("reset_miss_count", 64'(miss_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Clean read miss, lru=000 -> way 0, 3 wait cycles on fill
    run_txn(1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 0, 3, c0);
    check_lat("clean_miss_latency", c0, 7);
    // Write hit on way 2
    run_txn(1'b1, 1'b0, 2'd2, 3'b000, 1'b0, 0, 0, c0);
    check_lat("write_hit_latency", c0, 1);
    // Dirty miss, lru=101 -> victim way 3, wb 2 waits, fill 3 waits
    run_txn(1'b0, 1'b1, 2'd0, 3'b101, 1'b1, 2, 3, c0);
    check_lat("dirty_miss_latency", c0, 10);

    // Randomized traffic, memory waits kept under the timeout
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
              int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), c0);
      if ($urandom_range(3, 0) == 0) idle_cycles(int'($urandom_range(3, 1)));
    end

    // Fill withheld for 20 cycles: timeout flags but request still completes
    run_txn(1'b0, 1'b1, 2'd0, 3'($urandom), 1'b0, 0, 20, c0);
    check_lat("timeout_miss_latency", c0, 24);
    chk("err_timeout_sticky", 64'(err_timeout), 64'd1);
    run_txn(1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 0, 0, c0);

    // Reset in the middle of FILL
    begin_cycle();
    l2cmem_read = 1'b1; l2cmem_write = 1'b0;
    o = '0; o.ua = 1'b1; push(o);
    begin_cycle();
    hit = 1'b0; which_way_hit = 4'd0; lru_way = 3'b010; dirty_bit_out = 1'b0;
    o = '0; o.way = 2'd1; o.upa = 1'b1; push(o);
    if (PERF) m_mc++;
    begin_cycle();
    pmem_resp = 1'b0;
    o = '0; o.way = 2'd1; o.prd = 1'b1; push(o);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    l2cmem_read = 1'b0;
    #1;
    chk("rst_drops_pmem_read", 64'(pmem_read), 64'd0);
    chk("rst_all_outputs_zero", 64'(act_o), 64'd0);
    m_err = 1'b0; m_hc = '0; m_mc = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(4);

    // Performance counters: 3 read hits + 2 misses from a clean reset
    for (int i = 0; i < 3; i++) run_txn(1'b0, 1'b0, 2'($urandom), 3'd0, 1'b0, 0, 0, c0);
    for (int i = 0; i < 2; i++) run_txn(1'b0, 1'b1, 2'd0, 3'($urandom), 1'b0, 0, 1, c0);
    @(negedge clk);
    #1;
    chk("perf_hit_count", 64'(hit_count), PERF ? 64'd3 : 64'd0);
    chk("perf_miss_count", 64'(miss_count), PERF ? 64'd2 : 64'd0);

    idle_cycles(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Control FSM for the 4-way, 16-set, 256-bit-line L2 cache datapath.
- Accepts one read or write from the L1 side at a time and sequences the datapath through tag check, dirty writeback, line fill and install.
- Drives the physical-memory handshake, and raises l2cmem_resp and the LRU update strobe.

Parameters:
- PMEM_TIMEOUT, 0, cycles to wait for pmem_resp before flagging err_timeout; 0 disables the check.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- l2cmem_read  in  1  L1 read request, held until l2cmem_resp
- l2cmem_write  in  1  L1 write request (full line), held until l2cmem_resp
- hit  in  1  datapath: tag match in any valid way
- which_way_hit  in  4  datapath one-hot hit vector; bit3=way0, bit2=way1, bit1=way2, bit0=way3
- dirty_bit_out  in  1  dirty bit of the way on way_select
- lru_way  in  3  pseudo-LRU tree bits of the current set
- pmem_resp  in  1  physical memory done strobe
- l2cmem_resp  out  1  one-cycle completion to L1; also the datapath LRU write enable
- cache_write  out  1  write data/tag/valid/dirty of way_select
- valid_bit_in  out  1  valid value written with cache_write
- dirty_bit_in  out  1  dirty value written with cache_write
- way_select  out  2  way steering the datapath muxes and decoder
- pmem_address_sel  out  1  0 = request line address, 1 = victim tag|index
- dirty_write_sel  out  1  0 = install from pmem_rdata, 1 = install from l2cmem_wdata
- unleash_l2cmem_address  out  1  load request-address holding register
- unleash_l2cmem_wdata  out  1  load write-data holding register
- unleash_l2cmem_rdata  out  1  load victim line for writeback
- unleash_pmem_rdata  out  1  mirrors pmem_resp in FILL (datapath loads on pmem_resp)
- unleash_pmem_address  out  1  load pmem address register
- pmem_read  out  1  physical memory read request
- pmem_write  out  1  physical memory write request
- err_timeout  out  1  sticky; set when PMEM_TIMEOUT expires; cleared only by reset
- hit_count  out  32  L2_PERF_CNT_EN counter
- miss_count  out  32  L2_PERF_CNT_EN counter

Behaviour:
- Reset, asynchronous: state=IDLE; victim register=0; every output 0.
- Asserting rst_n low in any state, including WB or FILL, drops pmem_read and pmem_write immediately. The aborted request gets no l2cmem_resp.
- Every output not listed for a state is 0 in that state.
- States are IDLE, TAG, WB, FILL, INSTALL.
- IDLE:
  - When l2cmem_read or l2cmem_write is high, assert unleash_l2cmem_address, and also unleash_l2cmem_wdata if l2cmem_write is high.
  - Latch op=write if l2cmem_write is high (write has priority when both are high), then go to TAG.
- TAG (combinational on the registered address):
  - Hit way = lowest-numbered way set in which_way_hit; drive way_select = hit way.
  - Read hit: l2cmem_resp=1, then IDLE.
  - Write hit: cache_write=1, dirty_write_sel=1, valid_bit_in=1, dirty_bit_in=1, l2cmem_resp=1, then IDLE.
  - Miss:
    - Victim = lru_way[0] ? (lru_way[2] ? 3 : 2) : (lru_way[1] ? 1 : 0); drive way_select = victim and register it.
    - If dirty_bit_out=1: pmem_address_sel=1, unleash_pmem_address=1, unleash_l2cmem_rdata=1, then WB.
    - Otherwise: pmem_address_sel=0, unleash_pmem_address=1, then FILL.
- WB:
  - way_select = victim; pmem_write=1 until pmem_resp.
  - On pmem_resp: pmem_address_sel=0, unleash_pmem_address=1, then FILL.
- FILL:
  - way_select = victim; pmem_read=1; unleash_pmem_rdata follows pmem_resp.
  - On pmem_resp, go to INSTALL.
- INSTALL: way_select = victim, cache_write=1, dirty_write_sel=0, valid_bit_in=1, dirty_bit_in=0, then TAG. The re-check hits, so the TAG hit path completes the request and marks the line dirty for writes.
- Latency, request seen in IDLE at cycle 0:
  - Hit: l2cmem_resp at cycle 1.
  - Clean miss: fill latency + 4.
  - Dirty miss: writeback latency + fill latency + 5.
- pmem_resp outside WB and FILL is ignored.
- l2cmem_resp is exactly one cycle per request. A request still high in IDLE on the cycle after resp is treated as a new request.
- Timeout counter:
  - Clears on entry to WB or FILL and counts while waiting.
  - At PMEM_TIMEOUT it sets err_timeout and keeps waiting; the state is not abandoned.

Optional Feature:
- Macro L2_PERF_CNT_EN.
- Defined:
  - hit_count increments on each TAG cycle that hits on first entry from IDLE.
  - miss_count increments on each first-entry TAG miss.
  - The re-check after INSTALL counts in neither.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0 and the counter logic is absent.

Test Plan:
- Reset, then read at address 0x0000_0120 (index 9) into an empty cache -> pmem_read with pmem_address=0x0000_0120; pmem_resp after 3 cycles; install to way 0 (lru_way=000); l2cmem_resp 7 cycles after the request.
- Write hit on way 2 (which_way_hit=0010) -> at cycle 1: cache_write=1, way_select=2, dirty_write_sel=1, dirty_bit_in=1, l2cmem_resp=1; no pmem activity.
- Miss with lru_way=101 and victim way 3 dirty -> pmem_write first at victim tag|index address; then pmem_read at the request address; install to way 3 with dirty_bit_in=0.
- Assert rst_n low mid-FILL with pmem_read=1 -> pmem_read=0 the same cycle; state IDLE; no l2cmem_resp.
- PMEM_TIMEOUT=8 with pmem_resp withheld for 20 cycles -> err_timeout rises after 8 waiting cycles, stays high; request completes normally after resp.
- L2_PERF_CNT_EN: 3 read hits + 2 misses -> hit_count=3, miss_count=2.
